// File: rtl/reg_update_engine.sv
// reg_update_engine: four-register update engine with parallel and sequential modes.
// The a, b, c, d registers evolve for a programmed number of steps once a run
// is started from IDLE. b is only ever written by load. All arithmetic wraps
// modulo 2**WIDTH.
module reg_update_engine #(
    parameter int WIDTH = 32,
    parameter int K_SUB = 3,
    parameter int K_ADD = 10,
    parameter int K_INC = 1,
    parameter int SW    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] a_in,
    input  logic signed [WIDTH-1:0] b_in,
    input  logic signed [WIDTH-1:0] c_in,
    input  logic signed [WIDTH-1:0] d_in,
    input  logic                    start,
    input  logic        [SW-1:0]    steps,
    input  logic                    mode,
    output logic                    busy,
    output logic                    done,
    output logic        [SW-1:0]    step_cnt,
    output logic signed [WIDTH-1:0] a,
    output logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] c,
    output logic signed [WIDTH-1:0] d
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic signed [WIDTH-1:0] KSUB_W = WIDTH'(K_SUB);
    localparam logic signed [WIDTH-1:0] KADD_W = WIDTH'(K_ADD);
    localparam logic signed [WIDTH-1:0] KINC_W = WIDTH'(K_INC);

    logic [1:0]              state_q, state_d;
    logic signed [WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] b_q, b_d;
    logic signed [WIDTH-1:0] c_q, c_d;
    logic signed [WIDTH-1:0] d_q, d_d;
    logic [SW-1:0]           step_cnt_q, step_cnt_d;
    logic [SW-1:0]           steps_q, steps_d;
    logic                    mode_q, mode_d;

    // One-step results for both modes, computed from the current register values.
    logic signed [WIDTH-1:0] par_a, par_c, par_d;
    logic signed [WIDTH-1:0] seq_a, seq_c, seq_d;
    logic [SW-1:0]           step_next;

    // Parallel mode: every right-hand side sees pre-edge values.
    assign par_a = b_q + c_q;
    assign par_d = a_q - KSUB_W;
    assign par_c = c_q + KINC_W;

    // Sequential mode: each result feeds the next one within the same step.
    assign seq_a = b_q + c_q;
    assign seq_d = seq_a - KSUB_W;
    assign seq_c = seq_d + KADD_W + KINC_W;

    assign step_next = step_cnt_q + SW'(1);

    // Next-state and datapath selection for the IDLE/RUN/DONE controller.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        step_cnt_d = step_cnt_q;
        steps_d    = steps_q;
        mode_d     = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    // load wins over start; start is dropped this cycle.
                    a_d = a_in;
                    b_d = b_in;
                    c_d = c_in;
                    d_d = d_in;
                end else if (start) begin
                    step_cnt_d = '0;
                    steps_d    = steps;
                    mode_d     = mode;
                    state_d    = (steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (mode_q) begin
                    a_d = seq_a;
                    c_d = seq_c;
                    d_d = seq_d;
                end else begin
                    a_d = par_a;
                    c_d = par_c;
                    d_d = par_d;
                end
                step_cnt_d = step_next;
                if (step_next == steps_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            step_cnt_q <= '0;
            steps_q    <= '0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            step_cnt_q <= step_cnt_d;
            steps_q    <= steps_d;
            mode_q     <= mode_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign step_cnt = step_cnt_q;
    assign a        = a_q;
    assign b        = b_q;
    assign c        = c_q;
    assign d        = d_q;

endmodule

// File: tb/tb_reg_update_engine.sv
// Directed testbench for reg_update_engine: a 32-bit instance for the main
// sequences and an 8-bit instance for the wrap-around case.
module tb_reg_update_engine;

    logic clk = 1'b0;
    logic rst;

    // 32-bit instance stimulus and observation
    logic               load, start, mode;
    logic signed [31:0] a_in, b_in, c_in, d_in;
    logic        [7:0]  steps;
    logic               busy, done;
    logic        [7:0]  step_cnt;
    logic signed [31:0] a, b, c, d;

    // 8-bit instance stimulus and observation
    logic               load8, start8, mode8;
    logic signed [7:0]  a_in8, b_in8, c_in8, d_in8;
    logic        [7:0]  steps8;
    logic               busy8, done8;
    logic        [7:0]  step_cnt8;
    logic signed [7:0]  a8, b8, c8, d8;

    int checks = 0;
    int errors = 0;

    reg_update_engine #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .load(load),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .start(start), .steps(steps), .mode(mode),
        .busy(busy), .done(done), .step_cnt(step_cnt),
        .a(a), .b(b), .c(c), .d(d)
    );

    reg_update_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load(load8),
        .a_in(a_in8), .b_in(b_in8), .c_in(c_in8), .d_in(d_in8),
        .start(start8), .steps(steps8), .mode(mode8),
        .busy(busy8), .done(done8), .step_cnt(step_cnt8),
        .a(a8), .b(b8), .c(c8), .d(d8)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_regs(input int va, input int vb, input int vc, input int vd);
        load = 1'b1;
        a_in = va; b_in = vb; c_in = vc; d_in = vd;
        tick();
        load = 1'b0;
    endtask

    task automatic start_run(input int n, input logic m);
        start = 1'b1;
        steps = 8'(n);
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0; start = 1'b0; mode = 1'b0; steps = '0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0;
        load8 = 1'b0; start8 = 1'b0; mode8 = 1'b0; steps8 = '0;
        a_in8 = '0; b_in8 = '0; c_in8 = '0; d_in8 = '0;
        tick();
        tick();

        // Reset state
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_c", c, 0);
        check("rst_d", d, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", step_cnt, 0);
        rst = 1'b0;
        tick();

        // T1: one parallel step
        load_regs(30, 20, 15, 5);
        check("t1_load_a", a, 30);
        check("t1_load_b", b, 20);
        start_run(1, 1'b0);
        check("t1_busy", busy, 1);
        check("t1_cnt0", step_cnt, 0);
        tick();
        check("t1_busy_off", busy, 0);
        check("t1_done", done, 1);
        check("t1_a", a, 35);
        check("t1_c", c, 16);
        check("t1_d", d, 27);
        check("t1_b", b, 20);
        check("t1_cnt", step_cnt, 1);
        tick();
        check("t1_done_off", done, 0);

        // T2: two parallel steps
        load_regs(30, 20, 15, 5);
        start_run(2, 1'b0);
        tick();
        check("t2_s1_busy", busy, 1);
        check("t2_s1_a", a, 35);
        check("t2_s1_c", c, 16);
        check("t2_s1_d", d, 27);
        check("t2_s1_cnt", step_cnt, 1);
        tick();
        check("t2_done", done, 1);
        check("t2_a", a, 36);
        check("t2_c", c, 17);
        check("t2_d", d, 32);
        check("t2_cnt", step_cnt, 2);
        tick();

        // T3: one sequential step
        load_regs(30, 20, 15, 5);
        start_run(1, 1'b1);
        check("t3_busy", busy, 1);
        tick();
        check("t3_busy_off", busy, 0);
        check("t3_done", done, 1);
        check("t3_a", a, 35);
        check("t3_d", d, 32);
        check("t3_c", c, 43);
        check("t3_cnt", step_cnt, 1);
        tick();

        // T5: zero-step run, then load+start together
        start_run(0, 1'b0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 1);
        check("t5_cnt", step_cnt, 0);
        check("t5_a", a, 35);
        check("t5_c", c, 43);
        tick();
        check("t5_done_off", done, 0);
        start = 1'b1; steps = 8'd5;
        load_regs(1, 2, 3, 4);
        start = 1'b0;
        check("t5_ls_a", a, 1);
        check("t5_ls_d", d, 4);
        check("t5_ls_busy", busy, 0);
        tick();
        check("t5_ls_busy2", busy, 0);
        check("t5_ls_done", done, 0);

        // T6: long run, start/load ignored in RUN, reset aborts at step 4
        load_regs(30, 20, 15, 5);
        start_run(10, 1'b0);
        start = 1'b1; steps = 8'd1; mode = 1'b1;
        load = 1'b1; a_in = 99; b_in = 99; c_in = 99; d_in = 99;
        tick();
        tick();
        tick();
        check("t6_cnt3", step_cnt, 3);
        check("t6_a", a, 37);
        check("t6_b", b, 20);
        check("t6_c", c, 18);
        check("t6_d", d, 33);
        check("t6_busy", busy, 1);
        start = 1'b0; load = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_a", a, 0);
        check("t6_rst_c", c, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_cnt", step_cnt, 0);
        tick();
        check("t6_post_done", done, 0);
        check("t6_post_busy", busy, 0);

        // T4: 8-bit wrap
        load8 = 1'b1; a_in8 = 8'sd0; b_in8 = 8'sd127; c_in8 = 8'sd1; d_in8 = 8'sd0;
        tick();
        load8 = 1'b0;
        start8 = 1'b1; steps8 = 8'd1; mode8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        check("t4_done", done8, 1);
        check("t4_a", a8, -128);
        check("t4_d", d8, -3);
        check("t4_c", c8, 2);
        check("t4_b", b8, 127);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
